// File: rtl/key_stim.sv
// ---------------------------------------------------------------------------
// key_stim -- two-channel key stimulus generator (transmit end of the key
// interface). Each channel turns a single-cycle press request into a clean
// key level held for a programmed number of cycles, followed by a minimum
// release gap before the next request is accepted.
//
// Optional feature macro: KEY_BOUNCE_EN
//   When defined, each press and each release starts with a bounce burst:
//   BOUNCE_N toggle pairs, each half lasting BOUNCE_P cycles. When undefined
//   no bounce logic exists.
//
// Parameters:
//   HOLD_W      width of the hold-length inputs
//   GAP_CYCLES  key-released cycles after each press (>= 1)
//   BOUNCE_N    bounce toggle pairs per edge (KEY_BOUNCE_EN only, >= 1)
//   BOUNCE_P    cycles per bounce half-period (KEY_BOUNCE_EN only, >= 1)
//
// Ports:
//   in_clk          system clock
//   in_rst          asynchronous active-low reset
//   in_req_switch   switch channel press request
//   in_hold_switch  switch hold length, captured with the accepted request
//   in_req_reset    reset channel press request
//   in_hold_reset   reset hold length, captured with the accepted request
//   o_key_switch    switch key level, active-high
//   o_key_reset     reset key level, active-high
//   o_busy_switch   switch channel pressing or in gap
//   o_busy_reset    reset channel pressing or in gap
//   o_done_switch   one-cycle pulse when the switch channel returns to idle
//   o_done_reset    one-cycle pulse when the reset channel returns to idle
// ---------------------------------------------------------------------------

// One independent key channel. Ports: in_clk/in_rst as above, req/hold the
// press request and its hold length, key/busy/done the registered outputs.
module key_chan #(
  parameter int HOLD_W     = 16,
  parameter int GAP_CYCLES = 4,
  parameter int BOUNCE_N   = 3,
  parameter int BOUNCE_P   = 2
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              req,
  input  logic [HOLD_W-1:0] hold,
  output logic              key,
  output logic              busy,
  output logic              done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // Reject parameter values that would make a counter load zero and wrap.
  if (GAP_CYCLES < 1 || BOUNCE_N < 1 || BOUNCE_P < 1) begin : g_bad_param
    $error("key_chan: GAP_CYCLES, BOUNCE_N and BOUNCE_P must all be >= 1");
  end

`ifdef KEY_BOUNCE_EN
  localparam int HALF_W = $clog2(2 * BOUNCE_N + 1);
  localparam int PH_W   = $clog2(BOUNCE_P + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_BNC,
    PRESS,
    GAP_BNC,
    GAP
  } state_t;

  logic [HALF_W-1:0] half_q, half_d;
  logic [PH_W-1:0]   ph_q, ph_d;
`else
  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              key_q, key_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef KEY_BOUNCE_EN
      half_q  <= '0;
      ph_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef KEY_BOUNCE_EN
      half_q  <= half_d;
      ph_q    <= ph_d;
`endif
    end
  end

  // Next-state logic also computes the next output values, so every output
  // comes straight from a flop and changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    key_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef KEY_BOUNCE_EN
    half_d  = half_q;
    ph_d    = ph_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          // A zero hold still produces a one-cycle press.
          hold_d = (hold == '0) ? HOLD_W'(1) : hold;
          key_d  = 1'b1;
          busy_d = 1'b1;
`ifdef KEY_BOUNCE_EN
          state_d = PRESS_BNC;
          half_d  = HALF_W'(2 * BOUNCE_N);
          ph_d    = PH_W'(BOUNCE_P);
`else
          state_d = PRESS;
`endif
        end
      end

`ifdef KEY_BOUNCE_EN
      // Bounce burst: key flips every BOUNCE_P cycles for 2*BOUNCE_N halves,
      // starting high; the last half is low so the steady hold reads as a
      // fresh rising edge.
      PRESS_BNC: begin
        busy_d = 1'b1;
        if (ph_q == PH_W'(1)) begin
          ph_d = PH_W'(BOUNCE_P);
          if (half_q == HALF_W'(1)) begin
            state_d = PRESS;
            key_d   = 1'b1;
          end else begin
            half_d = half_q - 1'b1;
            key_d  = ~key_q;
          end
        end else begin
          ph_d  = ph_q - 1'b1;
          key_d = key_q;
        end
      end
`endif

      PRESS: begin
        busy_d = 1'b1;
        if (hold_q == HOLD_W'(1)) begin
          key_d = 1'b0;
`ifdef KEY_BOUNCE_EN
          state_d = GAP_BNC;
          half_d  = HALF_W'(2 * BOUNCE_N);
          ph_d    = PH_W'(BOUNCE_P);
`else
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES);
`endif
        end else begin
          hold_d = hold_q - 1'b1;
          key_d  = 1'b1;
        end
      end

`ifdef KEY_BOUNCE_EN
      // Release bounce mirrors the press bounce: starts low, ends high.
      GAP_BNC: begin
        busy_d = 1'b1;
        if (ph_q == PH_W'(1)) begin
          ph_d = PH_W'(BOUNCE_P);
          if (half_q == HALF_W'(1)) begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES);
            key_d   = 1'b0;
          end else begin
            half_d = half_q - 1'b1;
            key_d  = ~key_q;
          end
        end else begin
          ph_d  = ph_q - 1'b1;
          key_d = key_q;
        end
      end
`endif

      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d  = gap_q - 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

module key_stim #(
  parameter int HOLD_W     = 16,
  parameter int GAP_CYCLES = 4,
  parameter int BOUNCE_N   = 3,
  parameter int BOUNCE_P   = 2
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_req_switch,
  input  logic [HOLD_W-1:0] in_hold_switch,
  input  logic              in_req_reset,
  input  logic [HOLD_W-1:0] in_hold_reset,
  output logic              o_key_switch,
  output logic              o_key_reset,
  output logic              o_busy_switch,
  output logic              o_busy_reset,
  output logic              o_done_switch,
  output logic              o_done_reset
);

  key_chan #(
    .HOLD_W    (HOLD_W),
    .GAP_CYCLES(GAP_CYCLES),
    .BOUNCE_N  (BOUNCE_N),
    .BOUNCE_P  (BOUNCE_P)
  ) u_switch (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .req   (in_req_switch),
    .hold  (in_hold_switch),
    .key   (o_key_switch),
    .busy  (o_busy_switch),
    .done  (o_done_switch)
  );

  key_chan #(
    .HOLD_W    (HOLD_W),
    .GAP_CYCLES(GAP_CYCLES),
    .BOUNCE_N  (BOUNCE_N),
    .BOUNCE_P  (BOUNCE_P)
  ) u_reset (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .req   (in_req_reset),
    .hold  (in_hold_reset),
    .key   (o_key_reset),
    .busy  (o_busy_reset),
    .done  (o_done_reset)
  );

endmodule

// File: tb/tb_key_stim.sv
// ---------------------------------------------------------------------------
// tb_key_stim -- self-checking bench for key_stim.
// A timing model expresses each channel's expected outputs as a function of
// the number of edges since its accepted request; directed vectors, hand
// sequences for busy rejection, back-to-back presses and asynchronous reset,
// and random requests are all compared against it.
// ---------------------------------------------------------------------------
module tb_key_stim;

  localparam int HW = 16;
  localparam int G  = 4;
  localparam int BN = 3;
  localparam int BP = 2;
`ifdef KEY_BOUNCE_EN
  localparam int BT = 2 * BN * BP;
`else
  localparam int BT = 0;
`endif

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b0;
  logic          in_req_switch = 1'b0;
  logic [HW-1:0] in_hold_switch = '0;
  logic          in_req_reset = 1'b0;
  logic [HW-1:0] in_hold_reset = '0;
  logic          o_key_switch, o_key_reset;
  logic          o_busy_switch, o_busy_reset;
  logic          o_done_switch, o_done_reset;

  key_stim #(
    .HOLD_W    (HW),
    .GAP_CYCLES(G),
    .BOUNCE_N  (BN),
    .BOUNCE_P  (BP)
  ) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_req_switch (in_req_switch),
    .in_hold_switch(in_hold_switch),
    .in_req_reset  (in_req_reset),
    .in_hold_reset (in_hold_reset),
    .o_key_switch  (o_key_switch),
    .o_key_reset   (o_key_reset),
    .o_busy_switch (o_busy_switch),
    .o_busy_reset  (o_busy_reset),
    .o_done_switch (o_done_switch),
    .o_done_reset  (o_done_reset)
  );

  always #5 in_clk = ~in_clk;

  int assertCount = 0;
  int failCount   = 0;
  int edgeNo      = 0;

  // Model state per channel (0 = switch, 1 = reset)
  bit   mActive[2];
  int   mStart[2];
  int   mHold[2];
  bit   mBusyPrev[2];
  logic [5:0] expOut = '0;

  typedef struct {
    logic reqSw;
    int   holdSw;
    logic reqRs;
    int   holdRs;
    int   keySw;
    int   busySw;
    int   doneSw;
    int   keyRs;
    int   busyRs;
    int   doneRs;
  } vec_t;

  vec_t vecs[5];

  // Expected {key, busy, done} d edges after the accepting edge for an
  // effective hold h: press bounce, steady hold, release bounce, gap, done.
  function automatic logic [2:0] chanExpect(int d, int h);
    logic [2:0] r;
    r = 3'b000;
    if (d < BT)                r = {(((d / BP) % 2) == 0), 2'b10};
    else if (d < BT + h)       r = 3'b110;
    else if (d < 2 * BT + h)   r = {((((d - BT - h) / BP) % 2) == 1), 2'b10};
    else if (d < 2 * BT + h + G) r = 3'b010;
    else if (d == 2 * BT + h + G) r = 3'b001;
    return r;
  endfunction

  task automatic modelEdge();
    logic       req[2];
    int         hold[2];
    logic [2:0] e[2];
    req[0]  = in_req_switch;
    req[1]  = in_req_reset;
    hold[0] = int'(in_hold_switch);
    hold[1] = int'(in_hold_reset);
    for (int c = 0; c < 2; c++) begin
      e[c] = 3'b000;
      if (!in_rst) begin
        mActive[c]   = 1'b0;
        mBusyPrev[c] = 1'b0;
      end else begin
        if (!mBusyPrev[c] && req[c]) begin
          mActive[c] = 1'b1;
          mStart[c]  = edgeNo;
          mHold[c]   = (hold[c] == 0) ? 1 : hold[c];
        end
        if (mActive[c]) begin
          if (edgeNo - mStart[c] > 2 * BT + mHold[c] + G) mActive[c] = 1'b0;
          else e[c] = chanExpect(edgeNo - mStart[c], mHold[c]);
        end
        mBusyPrev[c] = e[c][1];
      end
    end
    expOut = {e[0][2], e[1][2], e[0][1], e[1][1], e[0][0], e[1][0]};
  endtask

  task automatic applyStimulus(input logic rs, input logic [HW-1:0] hs,
                               input logic rr, input logic [HW-1:0] hr);
    in_req_switch  = rs;
    in_hold_switch = hs;
    in_req_reset   = rr;
    in_hold_reset  = hr;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expected);
    logic [5:0] act;
    act = {o_key_switch, o_key_reset, o_busy_switch, o_busy_reset,
           o_done_switch, o_done_reset};
    assertCount++;
    if (act !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, edgeNo, act, expected);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int expected);
    assertCount++;
    if (act != expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNo, act, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge in_clk);
    edgeNo++;
    modelEdge();
    #1;
    checkOutput("cycle", expOut);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeNo);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kS, bS, dS, kR, bR, dR, doneCount;

    vecs[0] = '{1'b1, 5,  1'b0, 0, 5 + BT,  5 + G + 2*BT,  5 + G + 2*BT + 1,  0, 0, 0};
    vecs[1] = '{1'b1, 0,  1'b0, 0, 1 + BT,  1 + G + 2*BT,  1 + G + 2*BT + 1,  0, 0, 0};
    vecs[2] = '{1'b1, 3,  1'b1, 7, 3 + BT,  3 + G + 2*BT,  3 + G + 2*BT + 1,
                7 + BT, 7 + G + 2*BT, 7 + G + 2*BT + 1};
    vecs[3] = '{1'b0, 9,  1'b1, 2, 0, 0, 0, 2 + BT, 2 + G + 2*BT, 2 + G + 2*BT + 1};
    vecs[4] = '{1'b1, 12, 1'b1, 0, 12 + BT, 12 + G + 2*BT, 12 + G + 2*BT + 1,
                1 + BT, 1 + G + 2*BT, 1 + G + 2*BT + 1};

    // Reset state, then release and stay idle
    applyStimulus(1'b0, '0, 1'b0, '0);
    #3;
    checkOutput("reset_state", 6'b000000);
    stepCycle();
    stepCycle();
    in_rst = 1'b1;
    for (int i = 0; i < 10; i++) stepCycle();

    // Directed vectors: count key/busy cycles and locate the done pulse
    for (int v = 0; v < 5; v++) begin
      kS = 0; bS = 0; dS = 0; kR = 0; bR = 0; dR = 0;
      applyStimulus(vecs[v].reqSw, HW'(vecs[v].holdSw), vecs[v].reqRs, HW'(vecs[v].holdRs));
      for (int n = 1; n <= 2 * BT + 30; n++) begin
        stepCycle();
        if (n == 1) applyStimulus(1'b0, '0, 1'b0, '0);
        kS += int'(o_key_switch);
        bS += int'(o_busy_switch);
        kR += int'(o_key_reset);
        bR += int'(o_busy_reset);
        if (o_done_switch && dS == 0) dS = n;
        if (o_done_reset && dR == 0) dR = n;
      end
      checkValue($sformatf("vec%0d_key_sw", v),  kS, vecs[v].keySw);
      checkValue($sformatf("vec%0d_busy_sw", v), bS, vecs[v].busySw);
      checkValue($sformatf("vec%0d_done_sw", v), dS, vecs[v].doneSw);
      checkValue($sformatf("vec%0d_key_rs", v),  kR, vecs[v].keyRs);
      checkValue($sformatf("vec%0d_busy_rs", v), bR, vecs[v].busyRs);
      checkValue($sformatf("vec%0d_done_rs", v), dR, vecs[v].doneRs);
    end

    // Busy request ignored, then a request in the done cycle starts at once
    applyStimulus(1'b1, HW'(5), 1'b0, '0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    stepCycle();
    stepCycle();
    applyStimulus(1'b1, HW'(9), 1'b0, '0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    for (int n = 5; n <= 5 + G + 2 * BT; n++) stepCycle();
    stepCycle();
    checkValue("b2b_done", int'(o_done_switch), 1);
    applyStimulus(1'b1, HW'(2), 1'b0, '0);
    stepCycle();
    checkValue("b2b_key", int'(o_key_switch), 1);
    checkValue("b2b_busy", int'(o_busy_switch), 1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    for (int n = 0; n < 2 * BT + G + 10; n++) stepCycle();

    // Both channels, then asynchronous reset mid-press
    applyStimulus(1'b1, HW'(3), 1'b1, HW'(7));
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    stepCycle();
    #2;
    in_rst = 1'b0;
    #1;
    checkOutput("async_reset", 6'b000000);
    stepCycle();
    stepCycle();
    in_rst = 1'b1;
    doneCount = 0;
    for (int n = 0; n < 2 * BT + 30; n++) begin
      stepCycle();
      doneCount += int'(o_done_switch) + int'(o_done_reset);
    end
    checkValue("no_done_after_reset", doneCount, 0);

    // Held-high requests restart each time the channel returns to idle
    applyStimulus(1'b1, HW'(2), 1'b1, '0);
    for (int n = 0; n < 60; n++) stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    for (int n = 0; n < 2 * BT + G + 10; n++) stepCycle();

    // Random requests against the model
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, HW'($urandom_range(0, 10)),
                    $urandom_range(0, 2) == 0, HW'($urandom_range(0, 10)));
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
